// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the frame geometry (data bits, oversampling ratio, bits per frame),
// the flag bit positions used by the peripheral-bus register map, and a
// helper that converts an idle time in characters into s_tick counts.
package uart_pkg;

  localparam int unsigned DBIT       = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned FRAME_BITS = DBIT + 2;

  // Bit positions of the status flags in the bus register map.
  typedef enum logic [1:0] {
    FLAG_OVERFLOW  = 2'd0,
    FLAG_FRAME_ERR = 2'd1,
    FLAG_TIMEOUT   = 2'd2,
    FLAG_IRQ       = 2'd3
  } flag_bit_e;

  localparam int unsigned NUM_FLAGS = 4;

  // Oversample ticks spanning 'chars' full frames of 'dbit' data bits
  // (start + data + stop).
  function automatic int unsigned timeout_ticks(input int unsigned chars,
                                                input int unsigned dbit);
    return chars * (dbit + 2) * OVERSAMPLE;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   wr_en, wr_data      push; caller guarantees room (or a same-cycle pop)
//   rd_en               pop; caller guarantees the FIFO is not empty
//   flush               empty the FIFO; overrides push and pop
//   rd_data             current head entry
//   count, count_nxt    fill level now and after this clock edge
//   empty, full         fill-level decodes
module uart_rx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic                     flush,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign count_nxt = count_d;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));

endmodule

// File: rtl/uart_rx_ctrl.sv
// Control/buffer wrapper around a 16x-oversampling UART receiver core.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset (shared with core)
//   enable                receiver enable
//   divisor               baud divisor, f_clk/(16*baud) - 1
//   rx_pin / rx_sync      raw serial input / synchronised copy driving the core
//   s_tick                oversample tick driving the core
//   rx_done_tick, rx_dout frame-complete strobe and byte from the core
//   rd_en, rd_data        FIFO pop and first-word-fall-through head
//   empty, full, count    FIFO status
//   flush, clear_flags    FIFO flush and sticky-flag clear
//   overflow, frame_err,  sticky status flags
//   rx_timeout
//   irq                   level irq: fill >= IRQ_LEVEL or any flag
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DBIT          = uart_pkg::DBIT,
  parameter int unsigned DIV_W         = 11,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned IRQ_LEVEL     = 8,
  parameter int unsigned TIMEOUT_CHARS = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              divisor,
  input  logic                          rx_pin,
  output logic                          rx_sync,
  output logic                          s_tick,
  input  logic                          rx_done_tick,
  input  logic [DBIT-1:0]               rx_dout,
  input  logic                          rd_en,
  output logic [DBIT-1:0]               rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  input  logic                          flush,
  input  logic                          clear_flags,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          rx_timeout,
  output logic                          irq
);

  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TO_LIMIT = timeout_ticks(TIMEOUT_CHARS, DBIT);
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_LIMIT);

  // Baud tick generator
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0] div_q, div_d, div_cur;
  logic             s_tick_q, s_tick_d;

  // The divisor is sampled at the start of each period (counter at 0) and
  // held for the rest of it, so a change only takes effect after a wrap.
  always_comb begin
    div_cur    = (baud_cnt_q == '0) ? divisor : div_q;
    div_d      = div_cur;
    baud_cnt_d = '0;
    s_tick_d   = 1'b0;
    if (enable) begin
      s_tick_d   = (baud_cnt_q == div_cur);
      baud_cnt_d = s_tick_d ? '0 : baud_cnt_q + 1'b1;
    end
  end

  // Input synchroniser
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], rx_pin};
  end

  // Forcing the line high while disabled keeps the core idle.
  assign rx_sync = sync_q[1] | ~enable;
  assign s_tick  = s_tick_q;

  // Stop-bit check and FIFO handshake
  logic          wr_req, ferr_set, ovf_set, push_ok, pop;
  logic [CW-1:0] count_nxt;

  always_comb begin
    wr_req   = rx_done_tick & rx_sync;
    ferr_set = rx_done_tick & ~rx_sync;
    pop      = rd_en & ~empty & ~flush;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push_ok  = wr_req & ~flush & (~full | pop);
    ovf_set  = wr_req & ~flush & full & ~pop;
  end

  uart_rx_fifo #(
    .DATA_W (DBIT),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (push_ok),
    .wr_data   (rx_dout),
    .rd_en     (pop),
    .flush     (flush),
    .rd_data   (rd_data),
    .count     (count),
    .count_nxt (count_nxt),
    .empty     (empty),
    .full      (full)
  );

  // Receive timeout and sticky flags
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (push_ok | pop | flush | clear_flags) begin
      to_cnt_d = '0;
    end else if (!empty && s_tick_q && (to_cnt_q != TO_MAX)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    flags_d                 = '0;
    flags_d[FLAG_OVERFLOW]  = ovf_set  | (flags_q[FLAG_OVERFLOW]  & ~clear_flags);
    flags_d[FLAG_FRAME_ERR] = ferr_set | (flags_q[FLAG_FRAME_ERR] & ~clear_flags);
    flags_d[FLAG_TIMEOUT]   = (to_cnt_d == TO_MAX)
                            | (flags_q[FLAG_TIMEOUT] & ~clear_flags);
    // Built from next-state values so irq changes in step with count/flags.
    flags_d[FLAG_IRQ]       = (count_nxt >= CW'(IRQ_LEVEL))
                            | flags_d[FLAG_OVERFLOW]
                            | flags_d[FLAG_FRAME_ERR]
                            | flags_d[FLAG_TIMEOUT];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt_q <= '0;
      div_q      <= '0;
      s_tick_q   <= 1'b0;
      sync_q     <= '1;
      to_cnt_q   <= '0;
      flags_q    <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      s_tick_q   <= s_tick_d;
      sync_q     <= sync_d;
      to_cnt_q   <= to_cnt_d;
      flags_q    <= flags_d;
    end
  end

  assign overflow   = flags_q[FLAG_OVERFLOW];
  assign frame_err  = flags_q[FLAG_FRAME_ERR];
  assign rx_timeout = flags_q[FLAG_TIMEOUT];
  assign irq        = flags_q[FLAG_IRQ];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int unsigned DBIT     = 8;
  localparam int unsigned DIV_W    = 11;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned IRQ_LVL  = 8;
  localparam int unsigned TO_CHARS = 4;
  localparam int unsigned TO_LIMIT = TO_CHARS * (DBIT + 2) * 16;
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic [DIV_W-1:0] divisor = '0;
  logic             rx_pin = 1'b1;
  logic             rx_done_tick = 1'b0;
  logic [DBIT-1:0]  rx_dout = '0;
  logic             rd_en = 1'b0;
  logic             flush = 1'b0;
  logic             clear_flags = 1'b0;
  logic             rx_sync, s_tick, empty, full, overflow, frame_err, rx_timeout, irq;
  logic [DBIT-1:0]  rd_data;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DBIT          (DBIT),
    .DIV_W         (DIV_W),
    .FIFO_DEPTH    (DEPTH),
    .IRQ_LEVEL     (IRQ_LVL),
    .TIMEOUT_CHARS (TO_CHARS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .divisor      (divisor),
    .rx_pin       (rx_pin),
    .rx_sync      (rx_sync),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .flush        (flush),
    .clear_flags  (clear_flags),
    .overflow     (overflow),
    .frame_err    (frame_err),
    .rx_timeout   (rx_timeout),
    .irq          (irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mq[$];
  bit         m_ovf, m_ferr, m_tmo, m_tick, m_s1, m_s2;
  int         m_tcnt, m_tk_cnt, m_per;

  function automatic bit m_irq();
    return (mq.size() >= IRQ_LVL) || m_ovf || m_ferr || m_tmo;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit stop, was_empty, tick_now, pop, req, push, ovf_set, fe_set;
    if (!reset_n) begin
      mq.delete();
      m_ovf = 0; m_ferr = 0; m_tmo = 0; m_tick = 0;
      m_s1 = 1; m_s2 = 1;
      m_tcnt = 0; m_tk_cnt = 0; m_per = 0;
    end else begin
      stop      = enable ? m_s2 : 1'b1;
      was_empty = (mq.size() == 0);
      tick_now  = m_tick;
      req       = rx_done_tick && stop;
      fe_set    = rx_done_tick && !stop;
      pop       = 0; push = 0; ovf_set = 0;
      if (!flush) begin
        pop     = rd_en && !was_empty;
        push    = req && (mq.size() < DEPTH || pop);
        ovf_set = req && !push;
      end else begin
        mq.delete();
      end
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(rx_dout);

      if (push || pop || flush || clear_flags) m_tcnt = 0;
      else if (!was_empty && tick_now && m_tcnt < TO_LIMIT) m_tcnt++;

      m_ovf  = ovf_set || (m_ovf && !clear_flags);
      m_ferr = fe_set  || (m_ferr && !clear_flags);
      m_tmo  = (m_tcnt == TO_LIMIT) || (m_tmo && !clear_flags);

      // One tick per (period+1) clocks; the period is latched at each period start.
      if (!enable) begin
        m_tk_cnt = 0; m_tick = 0;
      end else begin
        if (m_tk_cnt == 0) m_per = int'(divisor);
        m_tick = (m_tk_cnt == m_per);
        m_tk_cnt = m_tick ? 0 : m_tk_cnt + 1;
      end
      m_s2 = m_s1;
      m_s1 = rx_pin;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("rx_sync", rx_sync, enable ? m_s2 : 1'b1);
      chk("s_tick", s_tick, m_tick);
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      if (mq.size() > 0) chk("rd_data", rd_data, mq[0]);
      chk("overflow", overflow, m_ovf);
      chk("frame_err", frame_err, m_ferr);
      chk("rx_timeout", rx_timeout, m_tmo);
      chk("irq", irq, m_irq());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc1();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc1();
      n++;
    end while (!s_tick && n < 64);
    if (!s_tick) chk("tick_wait", s_tick, 1);
  endtask

  // Bench-side stand-in for the core: serialise a frame at 16 clocks/bit
  // (divisor=0) and stop in the middle of the stop bit.
  task automatic send_frame_bits(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_pin = bits[i];
      repeat ((i == 9) ? 8 : 16) cyc1();
    end
  endtask

  task automatic quick_push(input logic [7:0] b, input logic stop);
    rx_pin = stop;
    repeat (3) cyc1();
    rx_done_tick = 1'b1;
    rx_dout = b;
    cyc1();
    rx_done_tick = 1'b0;
    rx_pin = 1'b1;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    cyc1();
    clear_flags = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    repeat (2) cyc1();
    chk("rst_rx_sync", rx_sync, 1);
    chk("rst_s_tick", s_tick, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rd_data", rd_data, 0);
    reset_n = 1'b1;

    // 1: baud ticks
    divisor = 11'd3;
    enable  = 1'b1;
    wait_tick(n);
    wait_tick(n); chk("tick_gap_div3", n, 4);
    wait_tick(n); chk("tick_gap_div3_b", n, 4);
    cyc1();
    divisor = 11'd0;
    wait_tick(n); chk("tick_old_period", n, 3);
    wait_tick(n); chk("tick_gap_div0", n, 1);
    wait_tick(n); chk("tick_gap_div0_b", n, 1);

    enable = 1'b0;
    rx_pin = 1'b0;
    repeat (3) cyc1();
    chk("dis_s_tick", s_tick, 0);
    chk("dis_rx_sync", rx_sync, 1);
    rx_pin = 1'b1;
    enable = 1'b1;
    repeat (3) cyc1();

    // 2: one frame of 0xA5
    send_frame_bits(8'hA5, 1'b1);
    chk("t2_empty_before", empty, 1);
    rx_done_tick = 1'b1;
    rx_dout = 8'hA5;
    cyc1();
    rx_done_tick = 1'b0;
    rx_pin = 1'b1;
    chk("t2_empty_after", empty, 0);
    chk("t2_rd_data", rd_data, 8'hA5);
    chk("t2_count", count, 1);
    rd_en = 1'b1;
    cyc1();
    rd_en = 1'b0;
    chk("t2_empty_pop", empty, 1);

    // 3: fill, overflow, drain in order
    for (int i = 0; i < 16; i++) quick_push(8'(i), 1'b1);
    chk("t3_full16", full, 1);
    quick_push(8'h55, 1'b1);
    chk("t3_full", full, 1);
    chk("t3_count", count, 16);
    chk("t3_overflow", overflow, 1);
    chk("t3_irq", irq, 1);
    for (int i = 0; i < 16; i++) begin
      chk("t3_pop_data", rd_data, 8'(i));
      rd_en = 1'b1;
      cyc1();
      rd_en = 1'b0;
    end
    chk("t3_empty", empty, 1);
    pulse_clear();
    chk("t3_ovf_cleared", overflow, 0);

    // 4: push+pop while full, then flush with a same-cycle push
    for (int i = 0; i < 16; i++) quick_push(8'(i), 1'b1);
    repeat (3) cyc1();
    rx_done_tick = 1'b1;
    rx_dout = 8'h77;
    rd_en = 1'b1;
    cyc1();
    rx_done_tick = 1'b0;
    rd_en = 1'b0;
    chk("t4_count", count, 16);
    chk("t4_overflow", overflow, 0);
    chk("t4_head", rd_data, 8'h01);
    flush = 1'b1;
    rx_done_tick = 1'b1;
    cyc1();
    flush = 1'b0;
    rx_done_tick = 1'b0;
    chk("t4_flush_count", count, 0);
    chk("t4_flush_empty", empty, 1);

    // 5: stop bit 0
    quick_push(8'h3C, 1'b0);
    chk("t5_frame_err", frame_err, 1);
    chk("t5_count", count, 0);
    chk("t5_irq", irq, 1);
    pulse_clear();
    chk("t5_cleared", frame_err, 0);
    chk("t5_irq_cleared", irq, 0);
    rx_pin = 1'b0;
    repeat (3) cyc1();
    rx_done_tick = 1'b1;
    clear_flags = 1'b1;
    cyc1();
    rx_done_tick = 1'b0;
    clear_flags = 1'b0;
    rx_pin = 1'b1;
    chk("t5_set_wins", frame_err, 1);
    pulse_clear();
    repeat (3) cyc1();

    // 6: receive timeout (divisor=0 -> one tick per clock)
    quick_push(8'h42, 1'b1);
    repeat (600) cyc1();
    chk("t6_no_timeout_yet", rx_timeout, 0);
    repeat (60) cyc1();
    chk("t6_timeout", rx_timeout, 1);
    chk("t6_irq", irq, 1);
    chk("t6_count", count, 1);

    // reset in the middle of a frame
    rx_pin = 1'b0;
    repeat (20) cyc1();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rx_sync", rx_sync, 1);
    chk("mid_rst_s_tick", s_tick, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_flags", {overflow, frame_err, rx_timeout}, 3'b000);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    rx_pin = 1'b1;
    cyc1();
    reset_n = 1'b1;
    repeat (5) cyc1();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
